// File: rtl/dynamic_obfuscation_pipe_if.sv
// Valid/ready stream bundle used on both sides of the obfuscation pipe.
// The master drives data/valid and the slave drives ready.
interface dynamic_obfuscation_pipe_if #(
    parameter int unsigned WIDTH = 64
);
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/dynamic_obfuscation_pipe.sv
// Key-gated obfuscation stage: genuine bits only where the loaded key matches GKey,
// LFSR decoy elsewhere, with a registered valid/ready output and a wrong-key lockout FSM.
module dynamic_obfuscation_pipe #(
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned MAX_FAIL  = 3,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_5EED
) (
    input  logic                                Clk,
    input  logic                                Rst_n,
    input  logic                                EN,
    dynamic_obfuscation_pipe_if.slave           i_stream,
    dynamic_obfuscation_pipe_if.master          o_stream,
    input  logic [WIDTH-1:0]                    InputKey,
    input  logic                                KeyLoad,
    input  logic [WIDTH-1:0]                    GKey,
    output logic                                DataGenuine,
    output logic                                Locked,
    output logic [$clog2(MAX_FAIL+1)-1:0]       FailCount
);
    localparam int unsigned FW   = $clog2(MAX_FAIL + 1);
    localparam logic [31:0] SEED = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;
    // Galois feedback mask for x^32+x^22+x^2+x+1 (right-shifting form)
    localparam logic [31:0] TAPS = 32'h8020_0003;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OPEN,
        ST_PARTIAL,
        ST_LOCKED
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [FW-1:0]    r_fail;
    logic [FW-1:0]    w_fail_nxt;
    logic [FW-1:0]    w_fail_inc;
    logic             w_key_load;
    logic [WIDTH-1:0] r_key;
    logic [31:0]      r_lfsr;
    logic [31:0]      w_lfsr_nxt;
    logic [WIDTH-1:0] r_dout;
    logic             r_valid;
    logic             r_genuine;
    logic             w_in_ready;
    logic             w_accept;
    logic [WIDTH-1:0] w_mask;
    logic [WIDTH-1:0] w_decoy;
    logic [WIDTH-1:0] w_word;

    assign w_in_ready     = EN && (!r_valid || o_stream.ready);
    assign w_accept       = i_stream.valid && w_in_ready;
    assign i_stream.ready = w_in_ready;
    assign o_stream.data  = r_dout;
    assign o_stream.valid = r_valid;
    assign DataGenuine    = r_genuine;
    assign Locked         = (r_state == ST_LOCKED);
    assign FailCount      = r_fail;
    assign w_fail_inc     = r_fail + FW'(1);
    assign w_lfsr_nxt     = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? TAPS : 32'h0);

    always_comb begin
        w_mask  = '0;
        w_decoy = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            w_decoy[i] = i_stream.data[i] ^ GKey[i] ^ r_lfsr[i % 32];
        end
        if (r_state == ST_OPEN || r_state == ST_PARTIAL) begin
            w_mask = ~(r_key ^ GKey);
        end
        w_word = (w_mask & i_stream.data) | (~w_mask & w_decoy);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fail_nxt  = r_fail;
        w_key_load  = 1'b0;
        if (KeyLoad && r_state != ST_LOCKED) begin
            w_key_load = 1'b1;
            if (InputKey == GKey) begin
                w_state_nxt = ST_OPEN;
                w_fail_nxt  = '0;
            end else begin
                w_fail_nxt  = w_fail_inc;
                w_state_nxt = (w_fail_inc == FW'(MAX_FAIL)) ? ST_LOCKED : ST_PARTIAL;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= ST_IDLE;
            r_fail  <= '0;
            r_key   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_fail  <= w_fail_nxt;
            if (w_key_load) begin
                r_key <= InputKey;
            end
        end
    end

    // The beat samples the pre-edge key/state, so a same-cycle KeyLoad only affects later beats
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_dout    <= '0;
            r_valid   <= 1'b0;
            r_genuine <= 1'b0;
            r_lfsr    <= SEED;
        end else if (w_accept) begin
            r_dout    <= w_word;
            r_valid   <= 1'b1;
            r_genuine <= (r_state == ST_OPEN);
            r_lfsr    <= w_lfsr_nxt;
        end else if (r_valid && o_stream.ready) begin
            r_valid   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_dynamic_obfuscation_pipe.sv
// Self-checking bench for dynamic_obfuscation_pipe: directed scenarios plus random
// traffic compared against a behavioural model of key state, decoy LFSR and output register.
module tb_dynamic_obfuscation_pipe;
    localparam int unsigned WIDTH    = 64;
    localparam int unsigned MAX_FAIL = 3;
    localparam logic [63:0] GOLD     = 64'hDEAD_BEEF_CAFE_F00D;
    localparam logic [31:0] SEED     = 32'hACE1_5EED;

    logic             Clk;
    logic             Rst_n;
    logic             EN;
    logic [WIDTH-1:0] InputKey;
    logic             KeyLoad;
    logic [WIDTH-1:0] GKey;
    logic             DataGenuine;
    logic             Locked;
    logic [1:0]       FailCount;

    dynamic_obfuscation_pipe_if #(.WIDTH(WIDTH)) in_if ();
    dynamic_obfuscation_pipe_if #(.WIDTH(WIDTH)) out_if ();

    dynamic_obfuscation_pipe #(
        .WIDTH(WIDTH),
        .MAX_FAIL(MAX_FAIL),
        .LFSR_SEED(SEED)
    ) dut (
        .Clk(Clk),
        .Rst_n(Rst_n),
        .EN(EN),
        .i_stream(in_if.slave),
        .o_stream(out_if.master),
        .InputKey(InputKey),
        .KeyLoad(KeyLoad),
        .GKey(GKey),
        .DataGenuine(DataGenuine),
        .Locked(Locked),
        .FailCount(FailCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic        m_valid;
    logic [63:0] m_dout;
    logic        m_gen;
    logic [31:0] m_lfsr;
    logic [63:0] m_key;
    logic        m_loaded;
    logic        m_locked;
    int          m_fail;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    // Polynomial given by its exponents; each nonzero term e feeds back into bit e-1
    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        int unsigned exps[4] = '{32, 22, 2, 1};
        logic [31:0] fb = '0;
        logic        out_bit;
        foreach (exps[k]) fb[exps[k]-1] = 1'b1;
        out_bit = l[0];
        l = l >> 1;
        return out_bit ? (l ^ fb) : l;
    endfunction

    function automatic logic [63:0] model_word(input logic [63:0] din);
        logic [63:0] mask;
        logic [63:0] res;
        mask = (m_loaded && !m_locked) ? ~(m_key ^ GKey) : 64'h0;
        for (int i = 0; i < 64; i++)
            res[i] = mask[i] ? din[i] : (din[i] ^ GKey[i] ^ m_lfsr[i % 32]);
        return res;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_dout = '0; m_gen = 0; m_lfsr = SEED;
        m_key = '0; m_loaded = 0; m_locked = 0; m_fail = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".valid"}, {63'h0, out_if.valid}, {63'h0, m_valid});
        check({tag, ".data"}, out_if.data, m_dout);
        check({tag, ".genuine"}, {63'h0, DataGenuine}, {63'h0, m_gen});
        check({tag, ".locked"}, {63'h0, Locked}, {63'h0, m_locked});
        check({tag, ".failcnt"}, {62'h0, FailCount}, 64'(m_fail));
    endtask

    // One clock: check InReady on pre-edge inputs, advance the model, check registered outputs
    task automatic tick(input string tag);
        logic acc;
        logic rdy;
        #1;
        rdy = EN && (!m_valid || out_if.ready);
        acc = in_if.valid && rdy;
        check({tag, ".inready"}, {63'h0, in_if.ready}, {63'h0, rdy});
        if (acc) begin
            m_dout  = model_word(in_if.data);
            m_gen   = m_loaded && !m_locked && (m_key == GKey);
            m_valid = 1;
            m_lfsr  = lfsr_step(m_lfsr);
        end else if (m_valid && out_if.ready) begin
            m_valid = 0;
        end
        if (KeyLoad && !m_locked) begin
            m_key    = InputKey;
            m_loaded = 1;
            if (InputKey == GKey) m_fail = 0;
            else begin
                m_fail++;
                if (m_fail == MAX_FAIL) m_locked = 1;
            end
        end
        @(posedge Clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset();
        Rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("reset");
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
    endtask

    task automatic idle_inputs();
        EN = 1; in_if.valid = 0; in_if.data = '0; out_if.ready = 1;
        KeyLoad = 0; InputKey = '0;
    endtask

    initial begin
        logic [63:0] held;
        GKey = GOLD;
        idle_inputs();
        Rst_n = 1'b0;
        #2;
        do_reset();

        // First beat with no key: fully decoy with the seed LFSR
        in_if.valid = 1; in_if.data = 64'h0123_4567_89AB_CDEF;
        tick("nokey");
        check("nokey.explicit", out_if.data, 64'h0123_4567_89AB_CDEF ^ GOLD ^ {2{SEED}});
        in_if.valid = 0;
        tick("nokey.drain");

        // Correct key, then four back-to-back genuine beats
        KeyLoad = 1; InputKey = GOLD;
        tick("goodkey");
        KeyLoad = 0;
        for (int i = 0; i < 4; i++) begin
            in_if.valid = 1; in_if.data = {$urandom, $urandom};
            held = in_if.data;
            tick("open");
            check("open.passthru", out_if.data, held);
        end
        in_if.valid = 0;
        tick("open.drain");

        // Key with bits 0 and 63 flipped: partial genuine
        KeyLoad = 1; InputKey = GOLD ^ 64'h8000_0000_0000_0001;
        tick("partkey");
        KeyLoad = 0;
        check("partkey.fail1", {62'h0, FailCount}, 64'd1);
        for (int i = 0; i < 2; i++) begin
            in_if.valid = 1; in_if.data = 64'h5555_AAAA_0F0F_F0F0;
            tick("partial");
            check("partial.mid", out_if.data & 64'h7FFF_FFFF_FFFF_FFFE,
                  64'h5555_AAAA_0F0F_F0F0 & 64'h7FFF_FFFF_FFFF_FFFE);
        end
        in_if.valid = 0;
        tick("partial.drain");

        // Three wrong loads lock; the correct key afterwards is ignored
        do_reset();
        for (int i = 0; i < 3; i++) begin
            KeyLoad = 1; InputKey = GOLD ^ (64'h1 << (4 * i));
            tick("wrong");
        end
        check("lock.locked", {63'h0, Locked}, 64'd1);
        check("lock.fail3", {62'h0, FailCount}, 64'd3);
        KeyLoad = 1; InputKey = GOLD;
        tick("lock.goodkey");
        KeyLoad = 0;
        check("lock.still3", {62'h0, FailCount}, 64'd3);
        in_if.valid = 1; in_if.data = 64'h0123_4567_89AB_CDEF;
        tick("lock.beat");
        check("lock.genuine0", {63'h0, DataGenuine}, 64'd0);
        in_if.valid = 0;
        tick("lock.drain");

        // Backpressure, same-cycle drain+load, and EN blocking
        do_reset();
        in_if.valid = 1; in_if.data = 64'h1111_2222_3333_4444;
        tick("bp.load");
        held = out_if.data;
        out_if.ready = 0; in_if.data = 64'h9999_8888_7777_6666;
        for (int i = 0; i < 5; i++) begin
            tick("bp.hold");
            check("bp.stable", out_if.data, held);
        end
        out_if.ready = 1;
        tick("bp.swap");
        EN = 0;
        tick("bp.en0");
        check("bp.en0.valid", {63'h0, out_if.valid}, 64'd0);
        EN = 1; in_if.valid = 0;

        // Same-cycle correct KeyLoad and beat from IDLE
        do_reset();
        KeyLoad = 1; InputKey = GOLD; in_if.valid = 1; in_if.data = 64'hCAFE_0000_BEEF_0000;
        tick("same.first");
        check("same.first.gen", {63'h0, DataGenuine}, 64'd0);
        KeyLoad = 0;
        tick("same.second");
        check("same.second.gen", {63'h0, DataGenuine}, 64'd1);
        // Reset with a word held: outputs clear without a clock edge
        do_reset();

        // Random traffic with occasional key loads and resets
        for (int c = 0; c < 400; c++) begin
            EN           = ($urandom_range(0, 3) != 0);
            in_if.valid  = $urandom_range(0, 1);
            in_if.data   = {$urandom, $urandom};
            out_if.ready = ($urandom_range(0, 2) != 0);
            KeyLoad      = ($urandom_range(0, 9) == 0);
            InputKey     = $urandom_range(0, 1) ? GOLD : (GOLD ^ (64'h1 << $urandom_range(0, 63)));
            tick("rand");
            if (c % 97 == 96) do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/dynamic_obfuscation_pipe.md
Name: dynamic_obfuscation_pipe

Overview:
- Parametrised, clocked successor of the per-bit key-gated obfuscation datapath.
- Each output bit carries the genuine input bit only where the loaded key bit matches the golden key (GKey); every other bit carries LFSR-scrambled decoy data that changes on every beat.
- Adds valid/ready streaming, a one-stage output register, and a key-attempt lockout state machine.
- Sits between the protected data source and the downstream consumer.

Parameters:
WIDTH, 64, datapath and key width in bits (>=1)
MAX_FAIL, 3, wrong key loads tolerated before permanent lock (>=1)
LFSR_SEED, 32'hACE1_5EED, reset value of 32-bit decoy LFSR; value 0 is replaced by 32'h1

Ports:
Clk  in  1  clock, rising edge
Rst_n  in  1  asynchronous active-low reset
EN  in  1  stream enable; 0 blocks acceptance of new beats
DataIn  in  WIDTH  input data word
InValid  in  1  DataIn valid
InReady  out  1  block can accept a beat
InputKey  in  WIDTH  candidate key
KeyLoad  in  1  single-cycle strobe: capture InputKey
GKey  in  WIDTH  golden key, static during operation
DataOut  out  WIDTH  registered obfuscated/genuine word
Data_valid  out  1  DataOut valid
OutReady  in  1  consumer accepts DataOut
DataGenuine  out  1  qualifier of current DataOut: 1 = all bits genuine
Locked  out  1  lockout active
FailCount  out  $clog2(MAX_FAIL+1)  wrong key loads since last good load

Behaviour:
- Reset (async assert, sync release): DataOut=0, Data_valid=0, DataGenuine=0, Locked=0, FailCount=0, key register=0, LFSR=seed, state=IDLE.
- States:
  - IDLE: no key loaded.
  - OPEN: last load matched GKey.
  - PARTIAL: last load mismatched, FailCount<MAX_FAIL.
  - LOCKED: terminal.
- Key load (KeyLoad=1, state != LOCKED):
  - Capture InputKey into the key register.
  - If InputKey==GKey: go to OPEN, FailCount=0.
  - Otherwise FailCount+1. If the new count equals MAX_FAIL, go to LOCKED with Locked=1; else go to PARTIAL.
- KeyLoad in LOCKED is ignored. Only Rst_n exits LOCKED.
- KeyLoad is honoured regardless of EN or the handshake.
- Per-bit mask M[i] = (key_reg[i]==GKey[i]) && state in {OPEN, PARTIAL}. In IDLE and LOCKED, M=0.
- Decoy D[i] = DataIn[i] ^ GKey[i] ^ lfsr[i mod 32].
- Output word W[i] = M[i] ? DataIn[i] : D[i].
- LFSR: Galois, polynomial x^32+x^22+x^2+x+1. Advances exactly once per accepted input beat, and only then.
- Handshake:
  - InReady = EN && (!Data_valid || OutReady), purely combinational.
  - Beat accepted when InValid && InReady.
  - On acceptance: DataOut<=W, Data_valid<=1, DataGenuine<=(state==OPEN). Latency 1 cycle.
  - If Data_valid && OutReady and no new beat is accepted: Data_valid<=0. DataOut and DataGenuine hold.
  - While Data_valid && !OutReady: DataOut, DataGenuine and Data_valid hold stable.
- Full throughput: a new beat may be accepted in the same cycle the held word is consumed.
- EN=0: no acceptance. A held word may still drain via OutReady.
- Simultaneous KeyLoad and accepted beat: the beat uses the key register and state from before the edge. The new key affects the next beat only.
- Words already in the output register are never re-masked after a key change.
- The FailCount saturation boundary is exactly MAX_FAIL; no wrap.
- Reset mid-stream discards the held word and drops Data_valid immediately.

Test Plan:
- Reset, then InValid=1, EN=1, DataIn=64'h0123_4567_89AB_CDEF with no key loaded -> 1 cycle later Data_valid=1, DataGenuine=0, DataOut = DataIn^GKey^{2{seed}}; LFSR advanced once.
- KeyLoad with InputKey==GKey=64'hDEAD_BEEF_CAFE_F00D, then stream 4 beats with OutReady=1 -> DataOut equals each DataIn, DataGenuine=1, one beat per cycle, FailCount=0.
- InputKey = GKey with bit 0 and bit 63 flipped -> DataOut bits 1..62 genuine; bits 0 and 63 equal decoy; DataGenuine=0; FailCount=1; decoy bits differ between two beats carrying identical DataIn.
- Three consecutive wrong KeyLoads (MAX_FAIL=3), then a correct KeyLoad -> Locked=1 after the third load; correct key ignored; all DataOut bits decoy; FailCount stays 3 until Rst_n.
- OutReady=0 for 5 cycles with a word held, InValid=1 -> InReady=0, DataOut/Data_valid stable; on OutReady=1 the held word drains and a new beat loads in the same cycle; EN=0 blocks acceptance.
- Same-cycle KeyLoad(correct) and accepted beat from IDLE -> that beat DataGenuine=0, next beat DataGenuine=1. Assert Rst_n=0 mid-stream -> all outputs 0 asynchronously.
